// File: rtl/vga_timing_pkg.sv
// Shared timing defaults and table-slice helpers for vga_window_gen.
// Tables pack mode 0 in the least significant slice.
`ifndef VGA_TIMING_PKG_SV
`define VGA_TIMING_PKG_SV

`define VGA_TBL_SLICE(tbl, idx, w) tbl[(w)*int'(idx) +: (w)]

package vga_timing_pkg;

  localparam int CNT_W_DEF   = 12;
  localparam int DLY_W_DEF   = 16;
  localparam int N_MODES_DEF = 4;

  localparam logic [CNT_W_DEF-1:0] PENTAGON_FRAME_W = 12'd896;
  localparam logic [CNT_W_DEF-1:0] PENTAGON_FRAME_H = 12'd640;
  localparam logic [CNT_W_DEF-1:0] PENTAGON_IMG_W   = 12'd720;
  localparam logic [CNT_W_DEF-1:0] PENTAGON_IMG_H   = 12'd576;
  localparam logic [DLY_W_DEF-1:0] PENTAGON_DLY     = 16'd14236;

  localparam logic [CNT_W_DEF-1:0] CLASSIC_FRAME_W  = 12'd896;
  localparam logic [CNT_W_DEF-1:0] CLASSIC_FRAME_H  = 12'd624;
  localparam logic [CNT_W_DEF-1:0] CLASSIC_IMG_W    = 12'd768;
  localparam logic [CNT_W_DEF-1:0] CLASSIC_IMG_H    = 12'd560;
  localparam logic [DLY_W_DEF-1:0] CLASSIC_DLY      = 16'd796;

  localparam logic [CNT_W_DEF-1:0] PROFI_FRAME_W    = 12'd768;
  localparam logic [CNT_W_DEF-1:0] PROFI_FRAME_H    = 12'd624;
  localparam logic [CNT_W_DEF-1:0] PROFI_IMG_W      = 12'd640;
  localparam logic [CNT_W_DEF-1:0] PROFI_IMG_H      = 12'd480;
  localparam logic [DLY_W_DEF-1:0] PROFI_DLY        = 16'd652;

  localparam logic [CNT_W_DEF-1:0] PROFI2_FRAME_W   = 12'd768;
  localparam logic [CNT_W_DEF-1:0] PROFI2_FRAME_H   = 12'd640;
  localparam logic [CNT_W_DEF-1:0] PROFI2_IMG_W     = 12'd640;
  localparam logic [CNT_W_DEF-1:0] PROFI2_IMG_H     = 12'd480;
  localparam logic [DLY_W_DEF-1:0] PROFI2_DLY       = 16'd652;

  localparam logic [N_MODES_DEF*CNT_W_DEF-1:0] FRAME_W_TBL_DEF =
    {PROFI2_FRAME_W, PROFI_FRAME_W, CLASSIC_FRAME_W, PENTAGON_FRAME_W};
  localparam logic [N_MODES_DEF*CNT_W_DEF-1:0] FRAME_H_TBL_DEF =
    {PROFI2_FRAME_H, PROFI_FRAME_H, CLASSIC_FRAME_H, PENTAGON_FRAME_H};
  localparam logic [N_MODES_DEF*CNT_W_DEF-1:0] IMG_W_TBL_DEF =
    {PROFI2_IMG_W, PROFI_IMG_W, CLASSIC_IMG_W, PENTAGON_IMG_W};
  localparam logic [N_MODES_DEF*CNT_W_DEF-1:0] IMG_H_TBL_DEF =
    {PROFI2_IMG_H, PROFI_IMG_H, CLASSIC_IMG_H, PENTAGON_IMG_H};
  localparam logic [N_MODES_DEF*DLY_W_DEF-1:0] START_DLY_TBL_DEF =
    {PROFI2_DLY, PROFI_DLY, CLASSIC_DLY, PENTAGON_DLY};

  // Requests outside the table fall back to mode 0.
  function automatic int sanitize_mode(input int m, input int n_modes);
    return (m >= n_modes) ? 0 : m;
  endfunction

endpackage

`endif

// File: rtl/vga_anchor_delay.sv
// Rising-edge detect on pix_start plus a saturating delay counter; anchor fires
// when the counter equals the selected delay.
module vga_anchor_delay #(
  parameter int DLY_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_start,
  input  logic [DLY_W-1:0] sel_dly,
  output logic             anchor,
  output logic             saturated
);

  localparam logic [DLY_W-1:0] DLY_SAT = {{(DLY_W-1){1'b1}}, 1'b0};

  logic             prev_q, prev_d;
  logic [DLY_W-1:0] delay_q, delay_d;

  // Latest edge always restarts the count; otherwise count up and park at DLY_SAT.
  always_comb begin
    prev_d  = pix_start;
    delay_d = delay_q;
    if (pix_start && !prev_q) begin
      delay_d = '0;
    end else if (delay_q != DLY_SAT) begin
      delay_d = delay_q + DLY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      delay_q <= DLY_SAT;
    end else begin
      prev_q  <= prev_d;
      delay_q <= delay_d;
    end
  end

  assign anchor    = (delay_q == sel_dly);
  assign saturated = (delay_q == DLY_SAT);

endmodule

// File: rtl/vga_window_gen.sv
// Active-window and blanking generator with per-mode timing table and
// pix_start re-anchoring. Define VGA_WINDOW_LOCK_EN to build the lock detector.
module vga_window_gen
  import vga_timing_pkg::*;
#(
  parameter int N_MODES = N_MODES_DEF,
  parameter int MODE_W  = 2,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DLY_W   = DLY_W_DEF,
  parameter logic [N_MODES*CNT_W-1:0] FRAME_W_TBL   = FRAME_W_TBL_DEF,
  parameter logic [N_MODES*CNT_W-1:0] FRAME_H_TBL   = FRAME_H_TBL_DEF,
  parameter logic [N_MODES*CNT_W-1:0] IMG_W_TBL     = IMG_W_TBL_DEF,
  parameter logic [N_MODES*CNT_W-1:0] IMG_H_TBL     = IMG_H_TBL_DEF,
  parameter logic [N_MODES*DLY_W-1:0] START_DLY_TBL = START_DLY_TBL_DEF,
  parameter int LOCK_FRAMES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_start,
  input  logic [MODE_W-1:0] mode,
  output logic              blank,
  output logic [CNT_W-1:0]  hcnt,
  output logic [CNT_W-1:0]  vcnt,
  output logic              frame_start,
  output logic              line_start,
  output logic [MODE_W-1:0] mode_cur,
  output logic              synced,
  output logic              locked
);

  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  vcnt_q, vcnt_d;
  logic [MODE_W-1:0] mode_cur_q, mode_cur_d;
  logic              synced_q, synced_d;

  logic [MODE_W-1:0] mode_req;
  logic [CNT_W-1:0]  frame_w, frame_h, img_w, img_h;
  logic [DLY_W-1:0]  sel_dly;
  logic              h_end, v_end, anchor, saturated;

  always_comb begin
    mode_req = MODE_W'(sanitize_mode(int'(mode), N_MODES));
    frame_w  = `VGA_TBL_SLICE(FRAME_W_TBL, mode_cur_q, CNT_W);
    frame_h  = `VGA_TBL_SLICE(FRAME_H_TBL, mode_cur_q, CNT_W);
    img_w    = `VGA_TBL_SLICE(IMG_W_TBL, mode_cur_q, CNT_W);
    img_h    = `VGA_TBL_SLICE(IMG_H_TBL, mode_cur_q, CNT_W);
    sel_dly  = `VGA_TBL_SLICE(START_DLY_TBL, mode_cur_q, DLY_W);
    h_end    = (hcnt_q >= frame_w - CNT_W'(1));
    v_end    = (vcnt_q >= frame_h - CNT_W'(1));
  end

  vga_anchor_delay #(
    .DLY_W (DLY_W)
  ) u_anchor_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_start (pix_start),
    .sel_dly   (sel_dly),
    .anchor    (anchor),
    .saturated (saturated)
  );

  // Counters hold at zero until the first anchor; >= compares make a switch to a
  // smaller mode wrap at the next opportunity instead of running off the end.
  always_comb begin
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    mode_cur_d = mode_cur_q;
    synced_d   = synced_q;
    if (anchor) begin
      hcnt_d     = '0;
      vcnt_d     = '0;
      mode_cur_d = mode_req;
      synced_d   = 1'b1;
    end else if (synced_q) begin
      if (h_end) begin
        hcnt_d = '0;
        if (v_end) begin
          vcnt_d     = '0;
          mode_cur_d = mode_req;
        end else begin
          vcnt_d = vcnt_q + CNT_W'(1);
        end
      end else begin
        hcnt_d = hcnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      mode_cur_q <= '0;
      synced_q   <= 1'b0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      mode_cur_q <= mode_cur_d;
      synced_q   <= synced_d;
    end
  end

`ifdef VGA_WINDOW_LOCK_EN
  localparam int LK_W = ($clog2(LOCK_FRAMES + 1) > 3) ? $clog2(LOCK_FRAMES + 1) : 3;

  logic [LK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic            locked_q, locked_d;

  // An anchor is aligned when the free-running raster was about to wrap anyway.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (saturated || (mode_cur_d != mode_cur_q)) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else if (anchor) begin
      if (synced_q && h_end && v_end) begin
        if (int'(lock_cnt_q) < LOCK_FRAMES) begin
          lock_cnt_d = lock_cnt_q + LK_W'(1);
        end
        if (int'(lock_cnt_q) + 1 >= LOCK_FRAMES) begin
          locked_d = 1'b1;
        end
      end else begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  logic unused_lock;
  assign unused_lock = saturated ^ (LOCK_FRAMES < 0);
  assign locked      = 1'b0;
`endif

  assign blank       = !synced_q || (hcnt_q >= img_w) || (vcnt_q >= img_h);
  assign frame_start = synced_q && (hcnt_q == '0) && (vcnt_q == '0);
  assign line_start  = synced_q && (hcnt_q == '0);
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign mode_cur    = mode_cur_q;
  assign synced      = synced_q;

endmodule

// File: tb/tb_vga_window_gen.sv
// Directed bench for vga_window_gen using a reduced three-mode timing table
// and an 8-bit delay counter so whole frames and saturation fit in a short run.
module tb_vga_window_gen;

  localparam int N_MODES = 3;
  localparam int MODE_W  = 2;
  localparam int CNT_W   = 12;
  localparam int DLY_W   = 8;

  // mode0: 20x6 frame, 14x4 image, delay 10
  // mode1: 16x5 frame, 12x3 image, delay 7
  // mode2: 12x4 frame,  8x2 image, delay 5
  localparam logic [N_MODES*CNT_W-1:0] FW_TBL  = {12'd12, 12'd16, 12'd20};
  localparam logic [N_MODES*CNT_W-1:0] FH_TBL  = {12'd4,  12'd5,  12'd6};
  localparam logic [N_MODES*CNT_W-1:0] IW_TBL  = {12'd8,  12'd12, 12'd14};
  localparam logic [N_MODES*CNT_W-1:0] IH_TBL  = {12'd2,  12'd3,  12'd4};
  localparam logic [N_MODES*DLY_W-1:0] DLY_TBL = {8'd5,   8'd7,   8'd10};

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pix_start = 1'b0;
  logic [MODE_W-1:0] mode = '0;
  logic              blank, frame_start, line_start, synced, locked;
  logic [CNT_W-1:0]  hcnt, vcnt;
  logic [MODE_W-1:0] mode_cur;

  int errors = 0;
  int checks = 0;
  int fs_pulses = 0;

  vga_window_gen #(
    .N_MODES       (N_MODES),
    .MODE_W        (MODE_W),
    .CNT_W         (CNT_W),
    .DLY_W         (DLY_W),
    .FRAME_W_TBL   (FW_TBL),
    .FRAME_H_TBL   (FH_TBL),
    .IMG_W_TBL     (IW_TBL),
    .IMG_H_TBL     (IH_TBL),
    .START_DLY_TBL (DLY_TBL),
    .LOCK_FRAMES   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_start   (pix_start),
    .mode        (mode),
    .blank       (blank),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .frame_start (frame_start),
    .line_start  (line_start),
    .mode_cur    (mode_cur),
    .synced      (synced),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_start) fs_pulses++;
  end

  // Drive inputs, then advance the given number of cycles; sampling happens on negedges.
  task automatic applyStimulus(input logic pix, input logic [MODE_W-1:0] m, input int cycles);
    pix_start = pix;
    mode      = m;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 2'd0, 2);
    checkOutput("rst_hcnt",     32'(hcnt),     32'd0);
    checkOutput("rst_vcnt",     32'(vcnt),     32'd0);
    checkOutput("rst_synced",   32'(synced),   32'd0);
    checkOutput("rst_blank",    32'(blank),    32'd1);
    checkOutput("rst_mode_cur", 32'(mode_cur), 32'd0);
    checkOutput("rst_locked",   32'(locked),   32'd0);
    rst_n = 1'b1;

    // No edge: nothing may start even after the delay counter would have wrapped.
    applyStimulus(1'b0, 2'd0, 300);
    checkOutput("idle_synced", 32'(synced), 32'd0);
    checkOutput("idle_hcnt",   32'(hcnt),   32'd0);
    checkOutput("idle_vcnt",   32'(vcnt),   32'd0);
    checkOutput("idle_blank",  32'(blank),  32'd1);
    #1;
    checkOutput("idle_no_frame_start", 32'(fs_pulses), 32'd0);

    // First anchor in mode 0: edge sampled, then delay 10, then load one cycle later.
    applyStimulus(1'b1, 2'd0, 1);
    applyStimulus(1'b0, 2'd0, 10);
    checkOutput("anchor_not_early", 32'(synced), 32'd0);
    applyStimulus(1'b0, 2'd0, 1);
    checkOutput("anchor_synced",      32'(synced),      32'd1);
    checkOutput("anchor_hcnt",        32'(hcnt),        32'd0);
    checkOutput("anchor_vcnt",        32'(vcnt),        32'd0);
    checkOutput("anchor_frame_start", 32'(frame_start), 32'd1);
    checkOutput("anchor_blank",       32'(blank),       32'd0);
    checkOutput("anchor_locked",      32'(locked),      32'd0);

    applyStimulus(1'b0, 2'd0, 13);
    checkOutput("m0_last_visible_hcnt",  32'(hcnt),  32'd13);
    checkOutput("m0_last_visible_blank", 32'(blank), 32'd0);
    applyStimulus(1'b0, 2'd0, 1);
    checkOutput("m0_first_hblank", 32'(blank), 32'd1);
    applyStimulus(1'b0, 2'd0, 5);
    checkOutput("m0_line_end_hcnt", 32'(hcnt), 32'd19);
    applyStimulus(1'b0, 2'd0, 1);
    checkOutput("m0_line_wrap_hcnt",  32'(hcnt),        32'd0);
    checkOutput("m0_line_wrap_vcnt",  32'(vcnt),        32'd1);
    checkOutput("m0_line_start",      32'(line_start),  32'd1);
    checkOutput("m0_no_frame_start",  32'(frame_start), 32'd0);
    applyStimulus(1'b0, 2'd0, 60);
    checkOutput("m0_vblank_vcnt",  32'(vcnt),  32'd4);
    checkOutput("m0_vblank_blank", 32'(blank), 32'd1);
    applyStimulus(1'b0, 2'd0, 39);
    checkOutput("m0_frame_end_hcnt", 32'(hcnt), 32'd19);
    checkOutput("m0_frame_end_vcnt", 32'(vcnt), 32'd5);
    applyStimulus(1'b0, 2'd0, 1);
    checkOutput("m0_frame_wrap_vcnt",  32'(vcnt),        32'd0);
    checkOutput("m0_frame_wrap_start", 32'(frame_start), 32'd1);

    // Mid-frame request for mode 2 waits for the natural frame wrap.
    applyStimulus(1'b0, 2'd2, 5);
    checkOutput("switch_held_early", 32'(mode_cur), 32'd0);
    applyStimulus(1'b0, 2'd2, 114);
    checkOutput("switch_held_last",  32'(mode_cur), 32'd0);
    applyStimulus(1'b0, 2'd2, 1);
    checkOutput("switch_applied",    32'(mode_cur), 32'd2);
    checkOutput("switch_wrap_hcnt",  32'(hcnt),     32'd0);
    applyStimulus(1'b0, 2'd2, 8);
    checkOutput("m2_hblank_at_8", 32'(blank), 32'd1);
    applyStimulus(1'b0, 2'd2, 3);
    checkOutput("m2_line_end_hcnt", 32'(hcnt), 32'd11);
    applyStimulus(1'b0, 2'd2, 1);
    checkOutput("m2_line_wrap_vcnt", 32'(vcnt),       32'd1);
    checkOutput("m2_line_start",     32'(line_start), 32'd1);

    // Out-of-range request (3 with three modes) falls back to mode 0 at the wrap.
    applyStimulus(1'b0, 2'd3, 35);
    checkOutput("sanitize_held", 32'(mode_cur), 32'd2);
    applyStimulus(1'b0, 2'd3, 1);
    checkOutput("sanitize_mode0", 32'(mode_cur), 32'd0);
    checkOutput("sanitize_vcnt",  32'(vcnt),     32'd0);

    // Two edges three cycles apart: only the later one anchors.
    applyStimulus(1'b1, 2'd1, 1);
    applyStimulus(1'b0, 2'd1, 2);
    applyStimulus(1'b1, 2'd1, 1);
    applyStimulus(1'b0, 2'd1, 8);
    checkOutput("restart_first_ignored", 32'(hcnt), 32'd12);
    applyStimulus(1'b0, 2'd1, 2);
    checkOutput("restart_pre_hcnt", 32'(hcnt),     32'd14);
    checkOutput("restart_pre_mode", 32'(mode_cur), 32'd0);
    applyStimulus(1'b0, 2'd1, 1);
    checkOutput("restart_anchor_hcnt", 32'(hcnt),        32'd0);
    checkOutput("restart_anchor_mode", 32'(mode_cur),    32'd1);
    checkOutput("restart_frame_start", 32'(frame_start), 32'd1);
    applyStimulus(1'b0, 2'd1, 16);
    checkOutput("m1_line_wrap_vcnt", 32'(vcnt), 32'd1);

    // Long free run past the delay saturation point: no spurious anchor (m=300 in an 80-clock frame).
    applyStimulus(1'b0, 2'd1, 284);
    checkOutput("sat_free_hcnt",  32'(hcnt),  32'd12);
    checkOutput("sat_free_vcnt",  32'(vcnt),  32'd3);
    checkOutput("sat_free_blank", 32'(blank), 32'd1);

    // Asynchronous reset mid-line.
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_hcnt",   32'(hcnt),     32'd0);
    checkOutput("async_rst_vcnt",   32'(vcnt),     32'd0);
    checkOutput("async_rst_synced", 32'(synced),   32'd0);
    checkOutput("async_rst_blank",  32'(blank),    32'd1);
    checkOutput("async_rst_mode",   32'(mode_cur), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd2, 3);
    checkOutput("post_rst_hcnt",   32'(hcnt),   32'd0);
    checkOutput("post_rst_synced", 32'(synced), 32'd0);

    // Recovery uses mode 0's delay, then adopts the requested mode 2.
    applyStimulus(1'b1, 2'd2, 1);
    applyStimulus(1'b0, 2'd2, 10);
    checkOutput("recover_not_early", 32'(synced), 32'd0);
    applyStimulus(1'b0, 2'd2, 1);
    checkOutput("recover_synced", 32'(synced),   32'd1);
    checkOutput("recover_mode",   32'(mode_cur), 32'd2);
    checkOutput("recover_hcnt",   32'(hcnt),     32'd0);
    applyStimulus(1'b0, 2'd2, 8);
    checkOutput("recover_m2_hblank", 32'(blank), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
